// File: rtl/if_stage.sv
// Instruction-fetch stage: owns PCF, a single-outstanding imem handshake,
// a one-entry skid buffer and the IF/ID pipeline register.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        PCSrcD,
  input  logic        JumpD,
  input  logic [31:0] PCBranchD,
  input  logic [31:0] PCJumpD,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

  state_t      state, state_n;
  logic [31:0] pcf, pcf_n;
  logic        kill, kill_n;
  logic        req_held, req_held_n;       // request shown, not yet accepted
  logic        redir_pend, redir_pend_n;   // redirect waiting for a held request to go
  logic [31:0] redir_pc, redir_pc_n;
  logic [31:0] skid_data, skid_data_n;
  logic [31:0] instr_n, pcplus4_n;
  logic        valid_n;

  logic        redirect, accept;
  logic [31:0] sel_target, target, pc_plus4;

  assign sel_target = PCSrcD ? PCBranchD : PCJumpD;
  assign target     = sel_target & 32'hFFFF_FFFC;
  assign pc_plus4   = pcf + 32'd4;
  assign redirect   = !StallD && ValidD && (PCSrcD || JumpD);

  // Gated by rst_n so no request escapes while reset is asserted.
  assign imem_req  = rst_n && (state == S_REQ) && (req_held || !StallF);
  assign imem_addr = pcf;
  assign accept    = imem_req && imem_ready;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_n      = state;
    pcf_n        = pcf;
    kill_n       = kill;
    req_held_n   = req_held;
    redir_pend_n = redir_pend;
    redir_pc_n   = redir_pc;
    skid_data_n  = skid_data;
    instr_n      = InstrD;
    pcplus4_n    = PCPlus4D;
    valid_n      = ValidD;

    // An unstalled IF/ID becomes a bubble unless an instruction is delivered below.
    if (!StallD) begin
      instr_n = '0;
      valid_n = 1'b0;
    end

    case (state)
      S_REQ: begin
        req_held_n = imem_req && !imem_ready;
        if (accept) begin
          state_n = S_WAIT;
          if (redir_pend) begin
            pcf_n        = redir_pc;
            redir_pend_n = 1'b0;
          end
        end
        if (redirect) begin
          if (imem_req && !imem_ready) begin
            // Address may not move mid-handshake: doom the request, retarget on accept.
            kill_n       = 1'b1;
            redir_pend_n = 1'b1;
            redir_pc_n   = target;
          end else begin
            pcf_n = target;
            if (accept) kill_n = 1'b1;
          end
        end
      end

      S_WAIT: begin
        if (imem_rvalid) begin
          state_n = S_REQ;
          if (kill) begin
            kill_n = 1'b0;
          end else if (redirect) begin
            pcf_n = target;
          end else if (!StallD) begin
            instr_n   = imem_rdata;
            pcplus4_n = pc_plus4;
            valid_n   = 1'b1;
            pcf_n     = pc_plus4;
          end else begin
            skid_data_n = imem_rdata;
            state_n     = S_HOLD;
          end
        end else if (redirect) begin
          kill_n = 1'b1;
          pcf_n  = target;
        end
      end

      S_HOLD: begin
        if (redirect) begin
          state_n = S_REQ;
          pcf_n   = target;
        end else if (!StallD) begin
          instr_n   = skid_data;
          pcplus4_n = pc_plus4;
          valid_n   = 1'b1;
          pcf_n     = pc_plus4;
          state_n   = S_REQ;
        end
      end

      default: state_n = S_REQ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_REQ;
      pcf        <= RESET_PC;
      kill       <= 1'b0;
      req_held   <= 1'b0;
      redir_pend <= 1'b0;
      redir_pc   <= '0;
      skid_data  <= '0;
      InstrD     <= '0;
      PCPlus4D   <= '0;
      ValidD     <= 1'b0;
    end else begin
      state      <= state_n;
      pcf        <= pcf_n;
      kill       <= kill_n;
      req_held   <= req_held_n;
      redir_pend <= redir_pend_n;
      redir_pc   <= redir_pc_n;
      skid_data  <= skid_data_n;
      InstrD     <= instr_n;
      PCPlus4D   <= pcplus4_n;
      ValidD     <= valid_n;
    end
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of decode.
- Owns the fetch PC (PCF), a single-outstanding request/response port to instruction memory, a one-entry skid buffer and the IF/ID pipeline register.
- Consumes StallF/StallD from the stall controller and the decode-stage branch/jump redirect.
- Produces InstrD/PCPlus4D/ValidD for decode. RsD/RtD are later derived from InstrD and fed back to the hazard logic.

Parameters:
RESET_PC, 32'h0000_0000, PCF value after reset; bits[1:0] must be 0.

Ports:
clk  input  1  pipeline clock, rising edge
rst_n  input  1  asynchronous active-low reset
StallF  input  1  stall-controller request: do not issue a new fetch
StallD  input  1  stall-controller request: hold IF/ID and skid buffer
PCSrcD  input  1  branch taken, resolved in decode
JumpD  input  1  jump, resolved in decode
PCBranchD  input  32  branch target
PCJumpD  input  32  jump target; PCSrcD has priority if both are set
imem_req  output  1  fetch request valid
imem_addr  output  32  fetch address (equals PCF)
imem_ready  input  1  memory accepts request this cycle
imem_rvalid  input  1  read data valid
imem_rdata  input  32  instruction word
InstrD  output  32  IF/ID instruction
PCPlus4D  output  32  IF/ID PC+4
ValidD  output  1  IF/ID holds a real instruction (0 = bubble)

Behaviour:
- Reset (async, rst_n=0):
  - PCF=RESET_PC, state=REQ, kill=0, skid buffer empty.
  - imem_req=0, InstrD=0, PCPlus4D=0, ValidD=0.
  - imem_req is forced 0 while rst_n=0.
- FSM states REQ, WAIT, HOLD:
  - REQ: imem_req = !StallF, imem_addr=PCF. Request is accepted when imem_req&&imem_ready → WAIT. Once asserted, imem_req and imem_addr stay stable until accepted, even if StallF rises.
  - WAIT: no request. On imem_rvalid:
    - kill=1 → discard the word, clear kill, → REQ.
    - else StallD=0 → load IF/ID {imem_rdata, PCF+4, 1}, PCF<=PCF+4, → REQ.
    - else StallD=1 → store the word in the skid buffer, → HOLD.
  - HOLD: when StallD=0, load IF/ID from the skid buffer, PCF<=PCF+4, → REQ.
- Bubbles: when IF/ID is not loaded with an instruction and StallD=0, it loads a bubble {0, PCPlus4D unchanged, 0}. When StallD=1, IF/ID holds its value.
- Redirect (PCSrcD||JumpD) is acted on only when StallD=0 and ValidD=1; otherwise it is ignored.
  - Target = selected target with bits[1:0] forced to 00.
  - PCF <= target.
  - IF/ID <= bubble. There is no delay slot.
  - Skid buffer is cleared.
  - In WAIT without rvalid, or in REQ with the request being accepted this cycle: kill<=1.
  - In REQ with the request not yet accepted: that request is marked kill and completes normally; imem_addr is not changed mid-handshake.
  - In WAIT with rvalid in the same cycle: the word is discarded, kill stays 0, → REQ.
  - In HOLD: → REQ.
- Priority: reset > redirect > StallD hold > instruction delivery.
- PC arithmetic is 32-bit modulo 2^32. PC+4 at 32'hFFFF_FFFC wraps to 0.
- Throughput: a 1-cycle memory (ready=1, rvalid in the cycle after acceptance) delivers one instruction per 2 cycles.
- Invariant: at most one outstanding request. No new request is issued while in WAIT or HOLD.

Test Plan:
1. Release reset; memory with ready=1 and rvalid one cycle after acceptance returns 32'h2008_0005 @0, 32'h2009_0003 @4 → imem_addr 0 then 4; InstrD shows each word with PCPlus4D 4 then 8, ValidD=1; a bubble appears between them.
2. StallD=1 for 3 cycles while rvalid returns 32'h8D0A_0000 @8 → word is held in HOLD; IF/ID unchanged; no imem_req; the cycle after StallD falls, InstrD=32'h8D0A_0000, PCPlus4D=12.
3. PCSrcD=1, PCBranchD=32'h0000_0041 while in WAIT @16 → IF/ID bubble; the late rvalid word is discarded (never reaches InstrD); next imem_addr=32'h0000_0040.
4. JumpD=1 and PCSrcD=1 in the same cycle as rvalid → word is dropped, next imem_addr=PCBranchD, kill stays 0.
5. imem_ready=0 for 4 cycles with StallF toggling → imem_req/imem_addr stay stable after first assertion; no duplicate request.
6. RESET_PC=32'hFFFF_FFFC → after one delivery, PCPlus4D=0 and next imem_addr=0; asserting rst_n=0 while in WAIT clears ValidD and imem_req asynchronously.
